// File: rtl/board_scan_sequencer.sv
// Chess-board sensor scan sequencer: drives one row at a time, samples the
// column returns, commits occupancy into an 8x8 map and reports changes.
// Optional per-square debounce is built when SCAN_DEBOUNCE_EN is defined.
module board_scan_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 40,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] col,
    output logic [7:0] row,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_done,
    output logic       chg_valid,
    output logic [5:0] chg_square,
    output logic       chg_occupied,
    input  logic       chg_ack,
    output logic       chg_overflow,
    input  logic       ovf_clear
);

    localparam int unsigned SETTLE_W = 8;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
        DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 3) begin : g_bad_param
        $error("board_scan_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [2:0]          ridx, ridx_next;
    logic [SETTLE_W-1:0] settle_cnt, settle_next;
    logic [7:0]          row_next;

    logic [7:0] sample;
    logic [7:0] map [8];
    logic [7:0] commit;
    logic [2:0] first_col;
    logic       multi;
    logic       ev;
    logic       ovf_set;

`ifdef SCAN_DEBOUNCE_EN
    logic [1:0] dcnt [8][8];
    logic [7:0] diff;
`endif

    // Sequencer register: state, row index, settle counter and row drive
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ridx       <= 3'd0;
            settle_cnt <= '0;
            row        <= 8'h00;
        end else begin
            state      <= state_next;
            ridx       <= ridx_next;
            settle_cnt <= settle_next;
            row        <= row_next;
        end
    end

    // Next-state logic; dropping enable always returns to IDLE at row 0
    always_comb begin
        state_next  = state;
        ridx_next   = ridx;
        settle_next = settle_cnt;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next  = DRIVE;
                    ridx_next   = 3'd0;
                    settle_next = '0;
                end
            end
            DRIVE: begin
                if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    state_next  = SAMPLE;
                    settle_next = '0;
                end else begin
                    settle_next = settle_cnt + SETTLE_W'(1);
                end
            end
            SAMPLE: state_next = UPDATE;
            UPDATE: begin
                state_next = DRIVE;
                ridx_next  = ridx + 3'd1;
            end
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next  = IDLE;
            ridx_next   = 3'd0;
            settle_next = '0;
        end
        row_next = (state_next == IDLE) ? 8'h00 : (8'h01 << ridx_next);
    end

`ifdef SCAN_DEBOUNCE_EN
    // Squares commit only after DEBOUNCE_SCANS consecutive differing samples
    always_comb begin
        diff   = sample ^ map[ridx];
        commit = 8'h00;
        for (int c = 0; c < 8; c++) begin
            commit[c] = diff[c] &&
                        ((3'(dcnt[ridx][c]) + 3'd1) == 3'(DEBOUNCE_SCANS));
        end
    end
`else
    // Every differing sample commits immediately
    always_comb begin
        commit = sample ^ map[ridx];
    end
`endif

    // Lowest committed column, multi-commit detect and overflow cause
    always_comb begin
        first_col = 3'd0;
        for (int c = 7; c >= 0; c--) begin
            if (commit[c]) first_col = 3'(c);
        end
        multi   = |(commit & (commit - 8'd1));
        ev      = (state == UPDATE) && (|commit);
        ovf_set = ev && ((chg_valid && !chg_ack) || multi);
    end

    // Sample capture, map commit, frame pulse and change-event registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sample       <= 8'h00;
            frame_done   <= 1'b0;
            chg_valid    <= 1'b0;
            chg_square   <= 6'd0;
            chg_occupied <= 1'b0;
            chg_overflow <= 1'b0;
            for (int r = 0; r < 8; r++) map[r] <= 8'h00;
        end else begin
            frame_done <= (state == UPDATE) && (ridx == 3'd7);
            if (state == SAMPLE) sample <= col;
            if (state == UPDATE) map[ridx] <= map[ridx] ^ commit;
            if (ev) begin
                if (!chg_valid || chg_ack) begin
                    chg_valid    <= 1'b1;
                    chg_square   <= {ridx, first_col};
                    chg_occupied <= sample[first_col];
                end
            end else if (chg_ack) begin
                chg_valid <= 1'b0;
            end
            chg_overflow <= ovf_set | (chg_overflow & ~ovf_clear);
        end
    end

`ifdef SCAN_DEBOUNCE_EN
    // Debounce counters advance on a differing sample, clear otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    dcnt[r][c] <= 2'd0;
        end else if (state == UPDATE) begin
            for (int c = 0; c < 8; c++) begin
                if (commit[c] || !diff[c]) dcnt[ridx][c] <= 2'd0;
                else                       dcnt[ridx][c] <= dcnt[ridx][c] + 2'd1;
            end
        end
    end
`endif

    assign rd_data = map[rd_addr];

endmodule
